// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with mid-bit sampling feeding a first-word-fall-through byte FIFO.
// Latency: byte visible on rx_valid/rx_data one clk after the stop-bit sample (~2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT from the falling edge).
// Backpressure: rx_ready pops the head; a byte completing on a full FIFO without a pop is dropped and sets sticky overrun.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clr_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [2:0]     idx;
  logic [7:0]     shreg;
  logic           rx_m;
  logic           rx_s;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;

  logic           stop_done;
  logic           push;
  logic           fe_event;
  logic           pop;
  logic           full;
  logic           wr_en;
  logic           ov_event;

  // Stop-bit sample decides between a push and a framing error in the same cycle.
  assign stop_done = (state == STOP) && (cnt == BIT_LAST);
  assign push      = stop_done && rx_s;
  assign fe_event  = stop_done && !rx_s;

  assign rx_valid  = (count != '0);
  assign rx_data   = rx_valid ? mem[rd_ptr] : 8'h00;
  assign pop       = rx_valid && rx_ready;
  assign full      = (count == FULL_CNT);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_en     = push && (!full || pop);
  assign ov_event  = push && full && !pop;

  // Two-flop synchroniser; reset to the idle level so reset never fakes a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Frame recovery: start qualification at half-bit, then one sample per bit period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            idx   <= idx + 1'b1;
            if (idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : BREAK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          cnt <= cnt + 1'b1;
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= shreg;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= fe_event | (frame_err & ~clr_err);
      overrun   <= ov_event | (overrun & ~clr_err);
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed frames plus randomized traffic against a queue-level model.
// Model schedules each frame's outcome at a fixed cycle offset from its start bit and tracks the FIFO as a queue.
// Outputs are compared every falling clk edge; literal checks pin timing, order, overrun and framing cases.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  // Drive after edge E0 -> 2 sync flops -> IDLE exit -> half bit -> 8 data bits + stop bit.
  localparam int LAT   = 3 + CPB / 2 + 9 * CPB;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       clr_err;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_err   (clr_err)
  );

  typedef struct {
    int         at;
    logic [7:0] b;
    bit         ok;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] mq[$];
  logic [7:0] got[$];
  bit         m_fe;
  bit         m_ov;
  bit         armed;
  int         cyc;
  int         total;
  int         bad;
  int         rdy_pct;
  bit         rdone;

  logic [7:0] exp2 [3] = '{8'hA3, 8'h00, 8'hFF};
  logic [7:0] exp3 [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h06};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model: frame outcomes land at their scheduled cycle; the FIFO is a plain queue.
  always @(posedge clk) begin : mdl
    bit         do_pop;
    bit         do_push;
    bit         new_fe;
    bit         new_ov;
    logic [7:0] pb;
    ev_t        e;
    cyc++;
    if (rst) begin
      mq.delete();
      evq.delete();
      m_fe  = 1'b0;
      m_ov  = 1'b0;
      armed = 1'b1;
    end else if (armed) begin
      do_pop  = (mq.size() != 0) && rx_ready;
      do_push = 1'b0;
      new_fe  = 1'b0;
      new_ov  = 1'b0;
      pb      = 8'h00;
      if (evq.size() != 0 && evq[0].at == cyc) begin
        e = evq.pop_front();
        if (e.ok) begin
          do_push = 1'b1;
          pb      = e.b;
        end else begin
          new_fe = 1'b1;
        end
      end
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        if (mq.size() < DEPTH) mq.push_back(pb);
        else new_ov = 1'b1;
      end
      m_fe = new_fe | (m_fe & ~clr_err);
      m_ov = new_ov | (m_ov & ~clr_err);
    end
  end

  // Per-cycle comparison of DUT outputs against the model, plus a log of accepted bytes.
  always @(negedge clk) begin
    if (armed) begin
      check("rx_valid", rx_valid, mq.size() != 0);
      if (mq.size() != 0) check("rx_data", rx_data, mq[0]);
      check("frame_err", frame_err, m_fe);
      check("overrun", overrun, m_ov);
      if (rx_valid && rx_ready) got.push_back(rx_data);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Serialise one frame; low_stop > 0 holds the line low that many bit times from the stop bit.
  task automatic send_frame(input logic [7:0] b, input int low_stop);
    ev_t e;
    e.at = cyc + LAT;
    e.b  = b;
    e.ok = (low_stop == 0);
    evq.push_back(e);
    rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(CPB);
    end
    if (low_stop == 0) begin
      rx = 1'b1;
      wait_cyc(CPB);
    end else begin
      rx = 1'b0;
      wait_cyc(CPB * low_stop);
      rx = 1'b1;
      wait_cyc(CPB);
    end
  endtask

  task automatic glitch(input int len);
    rx = 1'b0;
    wait_cyc(len);
    rx = 1'b1;
    wait_cyc(2 * CPB);
  endtask

  initial begin
    logic [7:0] b96;
    int         c;
    int         r;
    cyc      = 0;
    total    = 0;
    bad      = 0;
    armed    = 1'b0;
    rdone    = 1'b0;
    rdy_pct  = 50;
    rx       = 1'b1;
    rst      = 1'b1;
    rx_ready = 1'b0;
    clr_err  = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    check("reset_valid", rx_valid, 1'b0);
    check("reset_data", rx_data, 8'h00);
    check("reset_fe", frame_err, 1'b0);
    check("reset_ov", overrun, 1'b0);
    wait_cyc(5);

    // Single byte with continuous ready: one-cycle valid at the expected latency.
    rx_ready = 1'b1;
    fork
      send_frame(8'h55, 0);
      begin
        c = cyc;
        wait_cyc(LAT - 1);
        check("t1_before", rx_valid, 1'b0);
        wait_cyc(1);
        check("t1_valid", rx_valid, 1'b1);
        check("t1_data", rx_data, 8'h55);
        wait_cyc(1);
        check("t1_one_cycle", rx_valid, 1'b0);
      end
    join
    check("t1_fe", frame_err, 1'b0);
    check("t1_ov", overrun, 1'b0);

    // Three buffered bytes popped in order.
    rx_ready = 1'b0;
    send_frame(8'hA3, 0);
    send_frame(8'h00, 0);
    send_frame(8'hFF, 0);
    check("t2_head", rx_data, 8'hA3);
    got.delete();
    rx_ready = 1'b1;
    wait_cyc(5);
    rx_ready = 1'b0;
    check("t2_pops", got.size(), 3);
    for (int i = 0; i < 3; i++) if (i < got.size()) check("t2_order", got[i], exp2[i]);
    check("t2_empty", rx_valid, 1'b0);

    // Overrun on a full FIFO, clear, then push-with-pop on full.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0);
    check("t3_ov", overrun, 1'b1);
    check("t3_head", rx_data, 8'h01);
    clr_err = 1'b1;
    wait_cyc(1);
    clr_err = 1'b0;
    check("t3_ov_clr", overrun, 1'b0);
    check("t3_intact", rx_data, 8'h01);
    got.delete();
    fork
      send_frame(8'h06, 0);
      begin
        wait_cyc(LAT - 1);
        rx_ready = 1'b1;
      end
    join
    rx_ready = 1'b0;
    check("t3_no_ov", overrun, 1'b0);
    check("t3_pops", got.size(), 5);
    for (int i = 0; i < 5; i++) if (i < got.size()) check("t3_order", got[i], exp3[i]);
    check("t3_empty", rx_valid, 1'b0);

    // Framing error with a long break, then a clean byte.
    send_frame(8'h00, 12);
    check("t4_fe", frame_err, 1'b1);
    check("t4_nopush", rx_valid, 1'b0);
    wait_cyc(CPB);
    send_frame(8'h3C, 0);
    check("t4_valid", rx_valid, 1'b1);
    check("t4_data", rx_data, 8'h3C);
    clr_err = 1'b1;
    wait_cyc(1);
    clr_err = 1'b0;
    check("t4_fe_clr", frame_err, 1'b0);
    rx_ready = 1'b1;
    wait_cyc(2);
    rx_ready = 1'b0;

    // Short low pulse is rejected as a glitch.
    glitch(4);
    check("t5_novalid", rx_valid, 1'b0);
    check("t5_nofe", frame_err, 1'b0);

    // Reset in the middle of a frame, then a clean byte.
    b96 = 8'h96;
    rx  = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = b96[i];
      wait_cyc(CPB);
    end
    rx = b96[4];
    wait_cyc(CPB / 2);
    rx  = 1'b1;
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    check("t6_empty", rx_valid, 1'b0);
    wait_cyc(20);
    send_frame(8'h69, 0);
    check("t6_valid", rx_valid, 1'b1);
    check("t6_data", rx_data, 8'h69);
    rx_ready = 1'b1;
    wait_cyc(2);

    // Randomized traffic with varying consumer rate and occasional error clears.
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          r = $urandom_range(0, 9);
          case (k % 3)
            0:       rdy_pct = 3;
            1:       rdy_pct = 50;
            default: rdy_pct = 100;
          endcase
          if (r == 0) glitch($urandom_range(1, 6));
          else if (r == 1) send_frame(8'($urandom), $urandom_range(1, 3));
          else send_frame(8'($urandom), 0);
          wait_cyc($urandom_range(0, 40));
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          rx_ready = ($urandom_range(0, 99) < rdy_pct);
          clr_err  = ($urandom_range(0, 99) == 0);
          wait_cyc(1);
        end
        clr_err = 1'b0;
      end
    join
    rx_ready = 1'b1;
    wait_cyc(DEPTH + 4);
    check("final_empty", rx_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
